seq_mac_unit: RTL and testbench
===============================

Name: seq_mac_unit

Overview:
- Iterative shift-add multiply-accumulate unit for the TPU processing element datapath.
- Directly downstream of the full-adder bit slices: consumes their sum/carry outputs, chained into a 2*WIDTH ripple adder, and registers the partial product each cycle.
- Folds each finished product into a running accumulator.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 8: operand width in bits (unsigned); also the number of multiply iterations.
- ACC_WIDTH, 24: accumulator/result width in bits; must be >= 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  unit can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- acc_clear  input  1  sampled with a/b at acceptance; zeroes the accumulator and overflow before this product is added.
- out_valid  output  1  result holds a completed accumulation.
- out_ready  input  1  consumer takes result.
- result  output  ACC_WIDTH  registered accumulator value.
- overflow  output  1  sticky: accumulator carry-out has occurred since the last clear.

Behaviour:
- Reset values (synchronous, reset high at an edge):
  - state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0.
  - Accumulator, product, shift registers and counter all 0.
  - Reset overrides any in-flight operation; the partial product is discarded and no output is produced.
- FSM states: IDLE, MUL, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch mcand={WIDTH'0,a} (2*WIDTH bits), mplier=b, product=0, count=0; latch acc_clear into clr_pend; go to MUL.
- MUL (exactly WIDTH cycles, no early exit even if mplier becomes 0):
  - Each edge: if mplier[0], product <= product + mcand (2*WIDTH ripple add, carry-out discarded; it cannot occur for unsigned operands).
  - Also each edge: mcand <<= 1, mplier >>= 1, count++.
  - When count reaches WIDTH-1 on that edge, go to ACC.
- ACC (1 cycle):
  - base = clr_pend ? 0 : acc.
  - {c, acc} <= base + zero-extended product (ACC_WIDTH bits, wraps modulo 2^ACC_WIDTH).
  - overflow <= (clr_pend ? 0 : overflow) | c.
  - result <= new acc; go to DONE.
- DONE:
  - out_valid=1, in_ready=0; result and overflow held stable.
  - On out_ready: go to IDLE; out_valid drops on that edge.
- Latency: acceptance edge E0, then WIDTH MUL edges, then ACC edge. out_valid is high from the cycle following edge E(WIDTH+1), i.e. WIDTH+2 cycles after the acceptance cycle.
- Throughput: one operation per WIDTH+3 cycles minimum. No overlap: a new acceptance cannot occur in the same cycle as the out_ready handshake.
- Signal holding:
  - in_valid, a, b and acc_clear are ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - result retains its last value in IDLE/MUL/ACC and is not cleared on handshake.
- Boundary cases:
  - a=0 or b=0: product 0; acc unchanged unless clr_pend.
  - Max operands: (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Accumulator wrap sets overflow; it stays set until reset or an accepted acc_clear.

Test Plan:
- Basic product: reset, then a=3, b=5, acc_clear=1 -> out_valid rises exactly 10 cycles after the acceptance cycle (WIDTH=8); result=15, overflow=0; in_ready=0 throughout.
- Accumulation: three ops of a=255, b=255, with acc_clear=1 on the first only -> results 65025, 130050, 195075; overflow=0.
- Overflow and wrap: ACC_WIDTH=16; ops 255*255 (clear) then 255*255 -> second result=64514, overflow=1. A third op with acc_clear=1, a=2, b=2 -> result=4, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> result, out_valid=1 and overflow remain stable, in_ready=0, nothing accepted. Then out_ready=1 -> IDLE; the next op is accepted the following cycle.
- Zero and identity: a=0, b=200 (no clear) -> result unchanged from the prior value. a=1, b=170, clear -> result=170.
- Reset mid-operation: assert reset on the 4th MUL cycle of a=9, b=9 -> the next cycle shows in_ready=1, out_valid=0, result=0, overflow=0. A subsequent op a=2, b=3, clear -> result=6.

Source files
------------

// File: rtl/seq_mac_unit.sv
// seq_mac_unit: iterative shift-add multiply-accumulate unit.
// A WIDTH x WIDTH unsigned product is built over WIDTH cycles with a
// 2*WIDTH ripple adder made of full-adder slices. The product is then folded
// into a running ACC_WIDTH accumulator that has a sticky carry-out flag.
// Valid/ready handshakes are used on both the operand side and the result side.
module seq_mac_unit #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 overflow
);

    localparam int PW  = 2 * WIDTH;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int AW1 = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_t;

    // One full-adder bit slice: returns {carry_out, sum}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic cin);
        logic s;
        logic co;
        s  = x ^ y ^ cin;
        co = (x & y) | (x & cin) | (y & cin);
        return {co, s};
    endfunction

    // Ripple chain of full-adder slices. The carry-out is dropped because an
    // unsigned WIDTH x WIDTH product always fits in 2*WIDTH bits.
    function automatic logic [PW-1:0] ripple_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] r;
        logic          c;
        logic [1:0]    fa;
        c = 1'b0;
        for (int i = 0; i < PW; i++) begin
            fa   = full_adder(x[i], y[i], c);
            r[i] = fa[0];
            c    = fa[1];
        end
        return r;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [PW-1:0]          mcand_r;
    logic [WIDTH-1:0]       mplier_r;
    logic [PW-1:0]          product_r;
    logic [CW-1:0]          count_r;
    logic                   clr_pend_r;
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [ACC_WIDTH-1:0]   result_r;
    logic                   overflow_r;

    logic [PW-1:0]          partial_sum_s;
    logic [ACC_WIDTH-1:0]   acc_base_s;
    logic                   ovf_base_s;
    logic [AW1-1:0]         acc_sum_s;
    logic                   last_iter_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign overflow  = overflow_r;

    // Next-state decode for the control FSM.
    always_comb begin
        state_next_s = state_r;
        last_iter_s  = (count_r == CW'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (last_iter_s) begin
                    state_next_s = ACC;
                end else begin
                    state_next_s = MUL;
                end
            end
            ACC: begin
                state_next_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Arithmetic: the partial-product ripple add and the accumulator fold,
    // where a pending clear replaces the old accumulator and flag by zero.
    always_comb begin
        partial_sum_s = ripple_add(product_r, mcand_r);
        if (clr_pend_r) begin
            acc_base_s = {ACC_WIDTH{1'b0}};
            ovf_base_s = 1'b0;
        end else begin
            acc_base_s = acc_r;
            ovf_base_s = overflow_r;
        end
        acc_sum_s = {1'b0, acc_base_s} + AW1'(product_r);
    end

    // State register, with handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Datapath: operand capture, shift-add iterations and accumulator update.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r    <= {PW{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            product_r  <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            clr_pend_r <= 1'b0;
            acc_r      <= {ACC_WIDTH{1'b0}};
            result_r   <= {ACC_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r    <= {{WIDTH{1'b0}}, a};
                        mplier_r   <= b;
                        product_r  <= {PW{1'b0}};
                        count_r    <= {CW{1'b0}};
                        clr_pend_r <= acc_clear;
                    end
                end
                MUL: begin
                    if (mplier_r[0]) begin
                        product_r <= partial_sum_s;
                    end
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
                end
                ACC: begin
                    acc_r      <= acc_sum_s[ACC_WIDTH-1:0];
                    result_r   <= acc_sum_s[ACC_WIDTH-1:0];
                    overflow_r <= ovf_base_s | acc_sum_s[ACC_WIDTH];
                end
                DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mac_unit.sv
// Testbench for seq_mac_unit. Two instances share the same stimulus:
// one uses the default 24-bit accumulator and the other a 16-bit
// accumulator, which exercises wrap-around.
module tb_seq_mac_unit;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        acc_clear;
    logic        out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [23:0] res_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [15:0] res_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_mac_unit #(.WIDTH(W), .ACC_WIDTH(24)) dut24 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .a(a), .b(b), .acc_clear(acc_clear), .out_valid(out_valid_a),
        .out_ready(out_ready), .result(res_a), .overflow(ovf_a)
    );

    seq_mac_unit #(.WIDTH(W), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .a(a), .b(b), .acc_clear(acc_clear), .out_valid(out_valid_b),
        .out_ready(out_ready), .result(res_b), .overflow(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a busy/done countdown and the accumulator maths.
    int     phase = 0;
    longint m_res24, m_res16, p24, p16;
    bit     m_ovf24, m_ovf16, po24, po16;

    function automatic longint mac(input longint base, input logic [W-1:0] x, input logic [W-1:0] y);
        return base + longint'(x) * longint'(y);
    endfunction

    // Model update, evaluated at each rising edge with the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            phase   <= 0;
            m_res24 <= 0; m_ovf24 <= 1'b0;
            m_res16 <= 0; m_ovf16 <= 1'b0;
        end else if (phase == 0) begin
            if (in_valid) begin
                p24   <= mac(acc_clear ? 64'd0 : m_res24, a, b);
                p16   <= mac(acc_clear ? 64'd0 : m_res16, a, b);
                po24  <= acc_clear ? 1'b0 : m_ovf24;
                po16  <= acc_clear ? 1'b0 : m_ovf16;
                phase <= 1;
            end
        end else if (phase < W + 2) begin
            phase <= phase + 1;
            if (phase == W + 1) begin
                m_res24 <= p24 % 64'd16777216;
                m_ovf24 <= po24 | (p24 >= 64'd16777216);
                m_res16 <= p16 % 64'd65536;
                m_ovf16 <= po16 | (p16 >= 64'd65536);
            end
        end else if (out_ready) begin
            phase <= 0;
        end
    end

    // Compare the DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready24",  in_ready_a,  32'(phase == 0));
            chk("out_valid24", out_valid_a, 32'(phase == W + 2));
            chk("result24",    res_a,       32'(m_res24));
            chk("overflow24",  ovf_a,       32'(m_ovf24));
            chk("in_ready16",  in_ready_b,  32'(phase == 0));
            chk("out_valid16", out_valid_b, 32'(phase == W + 2));
            chk("result16",    res_b,       32'(m_res16));
            chk("overflow16",  ovf_b,       32'(m_ovf16));
        end
    end

    task automatic wait_result(input logic [31:0] e24, input bit o24,
                               input logic [31:0] e16, input bit o16);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid_a !== 1'b1 && n < 40);
        chk("latency", n, W + 2);
        chk("lit_res24", res_a, e24);
        chk("lit_ovf24", ovf_a, 32'(o24));
        chk("lit_res16", res_b, e16);
        chk("lit_ovf16", ovf_b, 32'(o16));
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit clr,
                         input logic [31:0] e24, input bit o24,
                         input logic [31:0] e16, input bit o16, input bit hs);
        int n;
        n = 0;
        while (in_ready_a !== 1'b1 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("idle_wait", 32'(n < 50), 32'd1);
        a = ta; b = tb; acc_clear = clr; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; acc_clear = 1'b0;
        wait_result(e24, o24, e16, o16);
        if (hs) begin
            out_ready = 1'b1;
            @(posedge clk); #2;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 32'd1);
        chk("rst_out_valid", out_valid_a, 32'd0);
        chk("rst_result", res_a, 32'd0);
        chk("rst_overflow", ovf_a, 32'd0);
        @(posedge clk); #2;

        // Basic product, then accumulation with wrap on the 16-bit instance.
        do_op(8'd3,   8'd5,   1'b1, 32'd15,     1'b0, 32'd15,    1'b0, 1'b1);
        do_op(8'd255, 8'd255, 1'b1, 32'd65025,  1'b0, 32'd65025, 1'b0, 1'b1);
        do_op(8'd255, 8'd255, 1'b0, 32'd130050, 1'b0, 32'd64514, 1'b1, 1'b1);
        do_op(8'd255, 8'd255, 1'b0, 32'd195075, 1'b0, 32'd64003, 1'b1, 1'b1);
        do_op(8'd2,   8'd2,   1'b1, 32'd4,      1'b0, 32'd4,     1'b0, 1'b1);

        // Backpressure: hold the result while new operands are offered.
        do_op(8'd7, 8'd9, 1'b0, 32'd67, 1'b0, 32'd67, 1'b0, 1'b0);
        a = 8'd11; b = 8'd13; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid_a, 32'd1);
            chk("bp_ready", in_ready_a, 32'd0);
            chk("bp_res", res_a, 32'd67);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", in_ready_a, 32'd1);
        chk("bp_idle_valid", out_valid_a, 32'd0);
        @(posedge clk); #2;
        in_valid = 1'b0;
        wait_result(32'd210, 1'b0, 32'd210, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;

        // Zero operand and identity.
        do_op(8'd0, 8'd200, 1'b0, 32'd210, 1'b0, 32'd210, 1'b0, 1'b1);
        do_op(8'd1, 8'd170, 1'b1, 32'd170, 1'b0, 32'd170, 1'b0, 1'b1);

        // Reset asserted during the fourth multiply cycle.
        a = 8'd9; b = 8'd9; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready_a, 32'd1);
        chk("mid_rst_out_valid", out_valid_a, 32'd0);
        chk("mid_rst_result", res_a, 32'd0);
        chk("mid_rst_overflow", ovf_a, 32'd0);
        chk("mid_rst_result16", res_b, 32'd0);
        @(posedge clk); #2;
        do_op(8'd2, 8'd3, 1'b1, 32'd6, 1'b0, 32'd6, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
